// File: rtl/ps_responder_pkg.sv
// ============================================================================
// Package    : ps_pkg
// Description: Shared types, defaults and phase-wrap helper for ps_responder.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps_pkg;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFTING = 2'd1,
    DONE     = 2'd2
  } ps_state_t;

  localparam int PS_DEFAULT_LATENCY = 12;
  localparam int PS_DEFAULT_STEPS   = 56;

  // Width of the phase position and of the latency down-counter
  localparam int PS_PHASE_W = 6;
  localparam int PS_CNT_W   = 8;

  // One step of the phase position with compare-and-wrap at both ends.
  // 'last' is the highest legal position (NUM_STEPS-1).
  function automatic logic [PS_PHASE_W-1:0] ps_step_phase(
    input logic [PS_PHASE_W-1:0] pos,
    input logic                  inc,
    input logic [PS_PHASE_W-1:0] last
  );
    logic [PS_PHASE_W-1:0] nxt;
    if (inc) begin
      nxt = (pos == last) ? '0 : pos + 1'b1;
    end else begin
      nxt = (pos == '0) ? last : pos - 1'b1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps_responder_if.sv
// ============================================================================
// Interface  : ps_responder_if
// Description: Phase-shift request/completion bundle between a requester
//              (master) and ps_responder (slave).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps_responder_if;
  import ps_pkg::*;

  logic                  psen;
  logic                  psincdec;
  logic                  drop_done;
  logic                  psdone;
  logic                  busy;
  logic [PS_PHASE_W-1:0] phase_pos;

  // Requester side: issues strobes, observes completion and position
  modport master (
    output psen,
    output psincdec,
    output drop_done,
    input  psdone,
    input  busy,
    input  phase_pos
  );

  // Responder side
  modport slave (
    input  psen,
    input  psincdec,
    input  drop_done,
    output psdone,
    output busy,
    output phase_pos
  );

endinterface

`default_nettype wire

// File: rtl/ps_responder.sv
// ============================================================================
// Module     : ps_responder
// Description: Phase-shift responder. Accepts a single-cycle psen strobe,
//              completes it LATENCY cycles later with a one-cycle psdone
//              pulse and moves phase_pos one step (wrapping modulo
//              NUM_STEPS). Requests arriving while busy are ignored.
//              Optional macro PS_RESP_ERR_EN adds err_sticky/err_count
//              tracking of requests that arrive while busy.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps_responder
  import ps_pkg::*;
#(
  parameter int LATENCY   = PS_DEFAULT_LATENCY,  // 2..255
  parameter int NUM_STEPS = PS_DEFAULT_STEPS     // 2..64
) (
  input  wire logic                  clk,
  input  wire logic                  rst_in,
  ps_responder_if.slave              ps
`ifdef PS_RESP_ERR_EN
  ,
  output logic                       err_sticky,
  output logic [7:0]                 err_count
`endif
);

  // The counter is loaded with LATENCY-2: one cycle is spent on the accept
  // edge, and the final edge (counter at zero) moves into DONE, so DONE
  // lands exactly LATENCY cycles after the accepting edge.
  localparam logic [PS_CNT_W-1:0]   LOAD_VAL  = PS_CNT_W'(LATENCY - 2);
  localparam logic [PS_PHASE_W-1:0] LAST_STEP = PS_PHASE_W'(NUM_STEPS - 1);

  ps_state_t             state_q, state_d;
  logic [PS_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  drop_q, drop_d;
  logic [PS_PHASE_W-1:0] phase_q, phase_d;
  logic                  psdone_q, psdone_d;

  // Next-state, counter and phase update for the request sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    drop_d   = drop_q;
    phase_d  = phase_q;
    psdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ps.psen) begin
          state_d = SHIFTING;
          cnt_d   = LOAD_VAL;
          dir_d   = ps.psincdec;
          drop_d  = ps.drop_done;
        end
      end

      SHIFTING: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          psdone_d = ~drop_q;
          if (!drop_q) begin
            phase_d = ps_step_phase(phase_q, dir_q, LAST_STEP);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards an in-flight request
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      drop_q   <= 1'b0;
      phase_q  <= '0;
      psdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      drop_q   <= drop_d;
      phase_q  <= phase_d;
      psdone_q <= psdone_d;
    end
  end

  assign ps.psdone    = psdone_q;
  assign ps.busy      = (state_q != IDLE);
  assign ps.phase_pos = phase_q;

`ifdef PS_RESP_ERR_EN
  // A strobe seen while a request is outstanding (including DONE)
  logic viol_w;
  assign viol_w = ps.psen && (state_q != IDLE);

  logic       err_sticky_q;
  logic [7:0] err_count_q;

  // Sticky violation flag and saturating violation counter
  always_ff @(posedge clk) begin
    if (rst_in) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else if (viol_w) begin
      err_sticky_q <= 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/ps_responder.md
PS_RESPONDER -- requirements
Module: ps_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 12, psen-to-psdone delay in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter NUM_STEPS, default 56, phase-position modulus, legal range 2..64.
REQ-003 SHALL have port clk  input  1  single clock (psclk domain); all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have port psen  input  1  single-cycle phase-shift request strobe.
REQ-006 SHALL have port psincdec  input  1  direction; 1 = increment, 0 = decrement; sampled with psen.
REQ-007 SHALL have port drop_done  input  1  fault injection; sampled with psen; suppresses that request's psdone.
REQ-008 SHALL have port psdone  output  1  single-cycle completion pulse.
REQ-009 SHALL have port busy  output  1  high while a request is outstanding.
REQ-010 SHALL have port phase_pos  output  6  current phase step, 0..NUM_STEPS-1.
REQ-011 SHALL have port err_sticky  output  1  protocol-violation flag; present only with PS_RESP_ERR_EN.
REQ-012 SHALL have port err_count  output  8  protocol-violation count; present only with PS_RESP_ERR_EN.

Function
REQ-013 SHALL implement states IDLE, SHIFTING, DONE.
REQ-014 In IDLE, psen=1 at edge t SHALL latch psincdec/drop_done, load the down-counter with LATENCY-2, and enter SHIFTING.
REQ-015 SHIFTING SHALL decrement the counter each cycle and enter DONE on the edge where it reaches 0.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-017 psdone SHALL be high during DONE only, i.e. exactly one cycle starting LATENCY cycles after the psen edge, unless drop_done was latched.
REQ-018 phase_pos SHALL update on the edge entering DONE: +1 wraps NUM_STEPS-1 -> 0; -1 wraps 0 -> NUM_STEPS-1.
REQ-019 With drop_done latched, DONE SHALL still occur with psdone=0 and phase_pos unchanged.
REQ-020 busy SHALL be high in SHIFTING and DONE and low in IDLE.
REQ-021 A psen arriving while busy=1, including the DONE cycle, SHALL be ignored and SHALL count as a protocol violation.
REQ-022 A psen in the first IDLE cycle after DONE SHALL be accepted normally.
REQ-023 psen in the same cycle as rst_in SHALL be ignored.
REQ-024 Phase arithmetic SHALL use 6-bit unsigned compare-and-wrap, with no modulo operator.

Reset
REQ-025 rst_in SHALL force state=IDLE, psdone=0, busy=0, phase_pos=0, counter=0, err_sticky=0 and err_count=0 on the next edge.
REQ-026 Reset during SHIFTING SHALL abort the request: no psdone and no phase_pos change afterwards.

Configuration
REQ-027 Macro PS_RESP_ERR_EN defined: err_sticky SHALL set on the first violation and hold until reset; err_count SHALL increment per violation and saturate at 255.
REQ-028 Macro PS_RESP_ERR_EN undefined: err_sticky, err_count and their logic SHALL be absent; violations SHALL be silently ignored; all other behaviour SHALL be identical.

Structure
REQ-029 Package ps_pkg SHALL hold the ps_state_t enum (IDLE, SHIFTING, DONE), PS_DEFAULT_LATENCY=12 and PS_DEFAULT_STEPS=56.
REQ-030 The block SHALL be a single module with no sub-module; the latency counter and wrap logic are too small to split.

Verification
REQ-031 Reset, then psen=1, psincdec=1 at cycle 0 -> psdone=1 at cycle 12 only; phase_pos=1 from cycle 12; busy high cycles 1..12.
REQ-032 56 spaced increments from phase_pos=0 -> phase_pos=0 after the last; then one decrement -> phase_pos=55.
REQ-033 psen at cycles 0 and 5 -> one psdone at cycle 12, phase_pos=1, err_count=1, err_sticky=1 (macro on); no error ports (macro off).
REQ-034 psen with drop_done=1 -> psdone never asserts; busy falls after cycle 12; phase_pos unchanged; next psen accepted at cycle 13.
REQ-035 psen at cycle 0, rst_in at cycle 6 -> no psdone through cycle 20; phase_pos=0; busy=0 from cycle 7.
REQ-036 LATENCY=2: psen at cycle 0 -> psdone at cycle 2; psen at cycle 3 -> psdone at cycle 5.
